fifo_data_reader: RTL and testbench

//   Read-side port of synchronous_fifo for the FIFO_DATA register (0x11). Pops one

---
 rtl/fifo_data_reader.sv | 144 ++++++++++++++
 tb/tb_fifo_data_reader.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_data_reader.sv
// Read-side port of the sample FIFO behind the FIFO_DATA register: pops one
// DATA_WIDTH-bit sample per BYTES byte requests and returns it MSB byte first.
module fifo_data_reader #(
    parameter int                    DATA_WIDTH = 24,
    parameter int                    BYTES      = 3,
    parameter int                    CNT_WIDTH  = 5,
    parameter logic [DATA_WIDTH-1:0] EMPTY_WORD = 24'h000002
) (
    input  logic                  mems_clk,
    input  logic                  rst_n,
    input  logic                  cs_n,
    input  logic                  byte_req,
    output logic                  byte_valid,
    output logic [7:0]            byte_data,
    input  logic                  fifo_empty,
    input  logic [CNT_WIDTH-1:0]  fifo_sample_num,
    input  logic [DATA_WIDTH-1:0] fifo_reg_data,
    output logic                  reg_fifo_read_en,
    output logic [7:0]            empty_reads
);

    localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_POP,
        ST_CAPT,
        ST_HOLD
    } state_t;

    state_t                r_state;
    logic [IDX_W-1:0]      r_byte_idx;
    logic [DATA_WIDTH-1:0] r_hold;
    logic                  r_byte_valid;
    logic [7:0]            r_byte_data;
    logic                  r_read_en;
    logic [7:0]            r_empty_reads;

    state_t                w_state_next;
    logic [IDX_W-1:0]      w_byte_idx_next;
    logic [DATA_WIDTH-1:0] w_hold_next;
    logic                  w_byte_valid_next;
    logic [7:0]            w_byte_data_next;
    logic                  w_read_en_next;
    logic [7:0]            w_empty_reads_next;
    logic                  w_emit;
    logic [DATA_WIDTH-1:0] w_emit_word;
    logic                  w_fifo_has_data;
    logic                  w_req_ok;
    logic                  w_last;

    // The FIFO counts as empty if either of its status signals says so.
    assign w_fifo_has_data = !fifo_empty && (fifo_sample_num != '0);
    assign w_req_ok        = byte_req && !r_byte_valid;
    assign w_last          = (r_byte_idx == IDX_W'(BYTES - 1));

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can infer a latch.
        w_state_next       = r_state;
        w_byte_idx_next    = r_byte_idx;
        w_hold_next        = r_hold;
        w_byte_valid_next  = 1'b0;
        w_byte_data_next   = r_byte_data;
        w_read_en_next     = 1'b0;
        w_empty_reads_next = r_empty_reads;
        w_emit             = 1'b0;
        w_emit_word        = r_hold;

        if (cs_n) begin
            w_state_next    = ST_IDLE;
            w_byte_idx_next = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_req_ok && (r_byte_idx == '0)) begin
                        if (w_fifo_has_data) begin
                            w_read_en_next = 1'b1;
                            w_state_next   = ST_POP;
                        end else begin
                            w_hold_next = EMPTY_WORD;
                            w_emit      = 1'b1;
                            w_emit_word = EMPTY_WORD;
                            if (r_empty_reads != 8'hFF) begin
                                w_empty_reads_next = r_empty_reads + 8'd1;
                            end
                        end
                    end
                end
                ST_POP: w_state_next = ST_CAPT;
                ST_CAPT: begin
                    w_hold_next = fifo_reg_data;
                    w_emit      = 1'b1;
                    w_emit_word = fifo_reg_data;
                end
                ST_HOLD: begin
                    if (w_req_ok) begin
                        w_emit = 1'b1;
                    end
                end
                default: w_state_next = ST_IDLE;
            endcase

            // Byte 0 is emitted on entry to HOLD; later bytes need a fresh request.
            if (w_emit) begin
                w_byte_data_next  = w_emit_word[(DATA_WIDTH - 1 - 8 * int'(r_byte_idx)) -: 8];
                w_byte_valid_next = 1'b1;
                if (w_last) begin
                    w_byte_idx_next = '0;
                    w_state_next    = ST_IDLE;
                end else begin
                    w_byte_idx_next = r_byte_idx + IDX_W'(1);
                    w_state_next    = ST_HOLD;
                end
            end
        end
    end

    always_ff @(posedge mems_clk) begin
        // NOTE: reset is sampled on the clock edge, and all state updates are non-blocking.
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_byte_idx    <= '0;
            r_hold        <= '0;
            r_byte_valid  <= 1'b0;
            r_byte_data   <= 8'h00;
            r_read_en     <= 1'b0;
            r_empty_reads <= 8'h00;
        end else begin
            r_state       <= w_state_next;
            r_byte_idx    <= w_byte_idx_next;
            r_hold        <= w_hold_next;
            r_byte_valid  <= w_byte_valid_next;
            r_byte_data   <= w_byte_data_next;
            r_read_en     <= w_read_en_next;
            r_empty_reads <= w_empty_reads_next;
        end
    end

    assign byte_valid       = r_byte_valid;
    assign byte_data        = r_byte_data;
    assign reg_fifo_read_en = r_read_en;
    assign empty_reads      = r_empty_reads;

endmodule

// File: tb/tb_fifo_data_reader.sv
// Bench for fifo_data_reader: a queue-backed FIFO environment plus a
// request/schedule model, checked every cycle, with directed literal expectations.
module tb_fifo_data_reader;

    localparam int          DW    = 24;
    localparam int          CW    = 5;
    localparam logic [23:0] EMPTY = 24'h000002;

    logic           mems_clk = 1'b0;
    logic           rst_n    = 1'b0;
    logic           cs_n     = 1'b1;
    logic           byte_req = 1'b0;
    logic           byte_valid;
    logic [7:0]     byte_data;
    logic           fifo_empty;
    logic [CW-1:0]  fifo_sample_num;
    logic [DW-1:0]  fifo_reg_data = '0;
    logic           reg_fifo_read_en;
    logic [7:0]     empty_reads;

    fifo_data_reader #(
        .DATA_WIDTH(DW), .BYTES(3), .CNT_WIDTH(CW), .EMPTY_WORD(EMPTY)
    ) dut (
        .mems_clk        (mems_clk),
        .rst_n           (rst_n),
        .cs_n            (cs_n),
        .byte_req        (byte_req),
        .byte_valid      (byte_valid),
        .byte_data       (byte_data),
        .fifo_empty      (fifo_empty),
        .fifo_sample_num (fifo_sample_num),
        .fifo_reg_data   (fifo_reg_data),
        .reg_fifo_read_en(reg_fifo_read_en),
        .empty_reads     (empty_reads)
    );

    initial forever #5 mems_clk = ~mems_clk;

    // FIFO environment: registered read data, one cycle after the pop strobe.
    logic [23:0] q[$];
    logic        force_empty    = 1'b0;
    logic        force_zero_num = 1'b0;
    int          underflows     = 0;

    assign fifo_empty      = force_empty || (q.size() == 0);
    assign fifo_sample_num = force_zero_num ? '0 : CW'(q.size());

    always @(posedge mems_clk) begin
        if (reg_fifo_read_en) begin
            if (q.size() > 0) begin
                fifo_reg_data <= q[0];
                q.pop_front();
            end else begin
                underflows++;
            end
        end
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s t=%0t got=%h want=%h", name, $time, act, exp);
        end
    endtask

    // Reference model: each accepted request schedules its outputs at absolute edges.
    int          k          = 0;
    int          idx        = 0;
    int          busy_until = -1;
    int          ren_at     = -1;
    int          emit_at    = -1;
    logic [7:0]  emit_byte  = 8'h00;
    logic [23:0] held       = '0;
    logic        e_valid    = 1'b0;
    logic        e_ren      = 1'b0;
    logic [7:0]  e_data     = 8'h00;
    logic [7:0]  e_er       = 8'h00;

    task automatic model_step();
        logic [23:0] sh;
        k++;
        e_valid = 1'b0;
        e_ren   = 1'b0;
        if (!rst_n) begin
            idx = 0; busy_until = -1; ren_at = -1; emit_at = -1;
            e_data = 8'h00; e_er = 8'h00;
        end else if (cs_n) begin
            idx = 0; busy_until = -1; ren_at = -1; emit_at = -1;
        end else if (byte_req && k > busy_until) begin
            if (idx == 0 && q.size() > 0 && !force_empty && !force_zero_num) begin
                held       = q[0];
                sh         = held >> 16;
                emit_byte  = sh[7:0];
                ren_at     = k;
                emit_at    = k + 2;
                idx        = 1;
                busy_until = k + 3;
            end else begin
                if (idx == 0) begin
                    held = EMPTY;
                    if (e_er != 8'hFF) e_er = e_er + 8'd1;
                end
                sh         = held >> (8 * (2 - idx));
                emit_byte  = sh[7:0];
                emit_at    = k;
                idx        = (idx + 1) % 3;
                busy_until = k + 1;
            end
        end
        if (ren_at == k) e_ren = 1'b1;
        if (emit_at == k) begin
            e_valid = 1'b1;
            e_data  = emit_byte;
        end
    endtask

    logic [7:0] got[$];
    logic [7:0] want[$];
    int         pop_cyc[$];

    task automatic compare();
        check("byte_valid", 32'(byte_valid), 32'(e_valid));
        check("read_en", 32'(reg_fifo_read_en), 32'(e_ren));
        check("byte_data", 32'(byte_data), 32'(e_data));
        check("empty_reads", 32'(empty_reads), 32'(e_er));
        if (byte_valid === 1'b1) got.push_back(byte_data);
        if (reg_fifo_read_en === 1'b1) pop_cyc.push_back(k);
    endtask

    task automatic cycle(input logic req, input logic cs, input logic rst = 1'b1);
        byte_req = req;
        cs_n     = cs;
        rst_n    = rst;
        model_step();
        @(negedge mems_clk);
        compare();
    endtask

    task automatic begin_test();
        got.delete();
        pop_cyc.delete();
    endtask

    task automatic check_got(input string name);
        logic [7:0] g;
        check({name, "_count"}, 32'(got.size()), 32'(want.size()));
        for (int i = 0; i < want.size(); i++) begin
            g = (i < got.size()) ? got[i] : 8'hxx;
            check(name, 32'(g), 32'(want[i]));
        end
    endtask

    task automatic spaced_reqs(input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            cycle(1'b1, 1'b0);
            repeat (gap - 1) cycle(1'b0, 1'b0);
        end
    endtask

    initial begin
        int gap;

        cycle(1'b0, 1'b1, 1'b0);
        check("rst_valid", 32'(byte_valid), 32'd0);
        check("rst_data", 32'(byte_data), 32'd0);
        check("rst_ren", 32'(reg_fifo_read_en), 32'd0);
        check("rst_er", 32'(empty_reads), 32'd0);
        cycle(1'b0, 1'b0);

        // 1: single word, three spaced requests
        begin_test();
        q.push_back(24'hA1B2C3);
        spaced_reqs(3, 5);
        want = '{8'hA1, 8'hB2, 8'hC3};
        check_got("t1_bytes");
        check("t1_pops", 32'(pop_cyc.size()), 32'd1);
        check("t1_fifo_left", 32'(q.size()), 32'd0);

        // 2: empty FIFO gives the empty-marker word
        begin_test();
        spaced_reqs(3, 3);
        want = '{8'h00, 8'h00, 8'h02};
        check_got("t2_bytes");
        check("t2_pops", 32'(pop_cyc.size()), 32'd0);
        check("t2_er", 32'(empty_reads), 32'd1);

        // 3: two words back to back
        begin_test();
        q.push_back(24'h123456);
        q.push_back(24'hABCDEF);
        spaced_reqs(6, 5);
        want = '{8'h12, 8'h34, 8'h56, 8'hAB, 8'hCD, 8'hEF};
        check_got("t3_bytes");
        check("t3_pops", 32'(pop_cyc.size()), 32'd2);
        gap = (pop_cyc.size() >= 2) ? pop_cyc[1] - pop_cyc[0] : 0;
        check("t3_pop_gap_ge3", 32'(gap >= 3), 32'd1);

        // 4: frame abort discards a partially sent word
        begin_test();
        q.push_back(24'h111111);
        q.push_back(24'h222222);
        spaced_reqs(1, 5);
        cycle(1'b0, 1'b1);
        cycle(1'b0, 1'b0);
        spaced_reqs(3, 5);
        want = '{8'h11, 8'h22, 8'h22, 8'h22};
        check_got("t4_bytes");
        check("t4_pops", 32'(pop_cyc.size()), 32'd2);

        // 5: request held high every cycle
        begin_test();
        q.push_back(24'h5A6B7C);
        repeat (10) cycle(1'b1, 1'b0);
        cycle(1'b0, 1'b1);
        cycle(1'b0, 1'b0);
        want = '{8'h5A, 8'h6B, 8'h7C, 8'h00};
        check_got("t5_bytes");
        check("t5_pops", 32'(pop_cyc.size()), 32'd1);
        check("t5_er", 32'(empty_reads), 32'd2);

        // Status disagreement: either flag alone means empty
        begin_test();
        q.push_back(24'hC0FFEE);
        force_zero_num = 1'b1;
        spaced_reqs(1, 4);
        cycle(1'b0, 1'b1);
        force_zero_num = 1'b0;
        force_empty    = 1'b1;
        spaced_reqs(1, 4);
        cycle(1'b0, 1'b1);
        force_empty = 1'b0;
        spaced_reqs(3, 5);
        want = '{8'h00, 8'h00, 8'hC0, 8'hFF, 8'hEE};
        check_got("t_flags_bytes");
        check("t_flags_pops", 32'(pop_cyc.size()), 32'd1);

        // Randomized traffic against the model
        for (int i = 0; i < 2500; i++) begin
            if (q.size() < 15 && $urandom_range(0, 7) == 0) q.push_back(24'($urandom));
            if ($urandom_range(0, 79) == 0) force_empty = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 79) == 0) force_zero_num = ($urandom_range(0, 3) == 0);
            cycle(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 49) == 0));
        end
        force_empty    = 1'b0;
        force_zero_num = 1'b0;

        // 6: saturate the empty-read counter, then reset
        cycle(1'b0, 1'b1);
        repeat (4) cycle(1'b0, 1'b0);
        q.delete();
        for (int i = 0; i < 260; i++) begin
            cycle(1'b1, 1'b0);
            cycle(1'b0, 1'b1);
        end
        check("t6_er_sat", 32'(empty_reads), 32'hFF);
        cycle(1'b0, 1'b0, 1'b0);
        check("t6_rst_er", 32'(empty_reads), 32'd0);
        check("t6_rst_valid", 32'(byte_valid), 32'd0);
        check("t6_rst_data", 32'(byte_data), 32'd0);
        check("t6_rst_ren", 32'(reg_fifo_read_en), 32'd0);
        cycle(1'b0, 1'b0);

        check("underflows", 32'(underflows), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
